// File: rtl/red_pitaya_sysbus_initiator.sv
// Single-outstanding initiator for the PS register bus: cmd valid/ready in, bus strobe, rsp out.
// Optional ack timeout is enabled by defining BUSINIT_TIMEOUT_EN.
module red_pitaya_sysbus_initiator #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [DW-1:0] cmd_wdata_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          rsp_err_o,
  output logic [AW-1:0] addr,
  output logic          wen,
  output logic          ren,
  output logic [DW-1:0] wdata,
  input  logic          ack,
  input  logic [DW-1:0] rdata,
  output logic          busy_o
);

  if (TIMEOUT < 2) begin : g_timeout_check
    $error("TIMEOUT must be at least 2");
  end

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStrobe = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wen_q, wen_d;
  logic          ren_q, ren_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          busy_q, busy_d;

`ifdef BUSINIT_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    busy_d      = busy_q;
`ifdef BUSINIT_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready_q) begin
          we_d        = cmd_we_i;
          addr_d      = cmd_addr_i;
          wdata_d     = cmd_wdata_i;
          wen_d       = cmd_we_i;
          ren_d       = ~cmd_we_i;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = StStrobe;
        end
      end
      StStrobe, StWait: begin
`ifdef BUSINIT_TIMEOUT_EN
        if (state_q == StStrobe) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        if (ack) begin
          // Responder drives rdata only in the ack cycle; writes return 0.
          rsp_rdata_d = we_q ? '0 : rdata;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          addr_d      = '0;
          wdata_d     = '0;
          state_d     = StResp;
`ifdef BUSINIT_TIMEOUT_EN
        end else if (state_q == StWait && cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          addr_d      = '0;
          wdata_d     = '0;
          state_d     = StResp;
`endif
        end else begin
          state_d = StWait;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

`ifdef BUSINIT_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
  assign rsp_err_o = rsp_err_q;
`else
  logic unused_err;
  assign unused_err = rsp_err_q;
  assign rsp_err_o  = 1'b0;
`endif

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign addr        = addr_q;
  assign wen         = wen_q;
  assign ren         = ren_q;
  assign wdata       = wdata_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_red_pitaya_sysbus_initiator.sv
// Bench for red_pitaya_sysbus_initiator: directed table, corner sequences and random transactions
// against a responder model with 1-cycle, zero-latency or never-ack behaviour.
module tb_red_pitaya_sysbus_initiator;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] addr;
  logic        wen, ren, ack, busy;
  logic [31:0] wdata, rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int strobe_cnt = 0;
  int both_hi  = 0;
  int strobe_cyc[$];

  // 0: ack one cycle after strobe, 1: combinational ack, 2: never ack
  int   resp_mode = 0;
  logic spur_ack  = 1'b0;
  logic ack_q;

  always #5 clk = ~clk;

  red_pitaya_sysbus_initiator #(.AW(16), .DW(32), .TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .addr        (addr),
    .wen         (wen),
    .ren         (ren),
    .wdata       (wdata),
    .ack         (ack),
    .rdata       (rdata),
    .busy_o      (busy)
  );

  // Responder register contents as seen by the bench.
  function automatic logic [31:0] rd_fn(input logic [15:0] a);
    return (a == 16'h0200) ? 32'd12 : {16'hC0DE, a ^ 16'h5A5A};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) ack_q <= 1'b0;
    else     ack_q <= (resp_mode == 0) && (wen || ren);
  end
  assign ack   = spur_ack | ((resp_mode == 1) ? (wen | ren) : ((resp_mode == 0) ? ack_q : 1'b0));
  assign rdata = rd_fn(addr);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wen || ren) begin
      strobe_cnt <= strobe_cnt + 1;
      strobe_cyc.push_back(cyc);
    end
    if (wen && ren) both_hi <= both_hi + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // One transaction; exp_lat = clock edges after the accept edge until rsp_valid is seen.
  task automatic run_txn(input string nm, input logic we, input logic [15:0] a,
                         input logic [31:0] d, input int hold, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_lat);
    int s0;
    int lat;
    @(negedge clk);
    check({nm, ":ready"}, 32'(cmd_ready), 32'd1);
    cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    rsp_ready = (hold == 0);
    s0 = strobe_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check({nm, ":strobe"}, {30'd0, wen, ren}, {30'd0, we, ~we});
    check({nm, ":addr"}, 32'(addr), 32'(a));
    if (we) check({nm, ":wdata"}, wdata, d);
    check({nm, ":ready_low"}, 32'(cmd_ready), 32'd0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_valid && lat < 400);
    check({nm, ":latency"}, 32'(lat), 32'(exp_lat));
    check({nm, ":rdata"}, rsp_rdata, exp_rd);
    check({nm, ":err"}, 32'(rsp_err), 32'(exp_err));
    check({nm, ":bus_idle"}, {14'd0, wen, ren, addr}, 32'd0);
    if (hold > 0) begin
      cmd_valid = 1'b1; cmd_we = ~we; cmd_addr = ~a;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({nm, ":hold"}, {rsp_valid, cmd_ready, 30'd0}, {1'b1, 1'b0, 30'd0});
        check({nm, ":hold_rdata"}, rsp_rdata, exp_rd);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({nm, ":done"}, {29'd0, rsp_valid, cmd_ready, busy}, 32'b010);
    @(negedge clk);
    check({nm, ":strobes"}, 32'(strobe_cnt - s0), 32'd1);
  endtask

  task automatic b2b(input string nm, input int mode, input int gap);
    int acc[3];
    int k;
    resp_mode = mode; rsp_ready = 1'b1;
    strobe_cyc.delete();
    @(negedge clk);
    k = 0; cmd_we = 1'b1; cmd_addr = 16'h0400; cmd_wdata = 32'd0; cmd_valid = 1'b1;
    for (int t = 0; t < 60 && k < 3; t++) begin
      if (cmd_ready) begin
        acc[k] = cyc + 1;
        k++;
        @(posedge clk); #1;
        if (k < 3) begin
          cmd_addr = 16'h0400 + 16'(k); cmd_wdata = 32'(k);
        end else cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check({nm, ":accepted"}, 32'(k), 32'd3);
    repeat (8) @(negedge clk);
    check({nm, ":n_strobes"}, 32'(strobe_cyc.size()), 32'd3);
    if (strobe_cyc.size() == 3 && k == 3) begin
      for (int i = 0; i < 3; i++)
        check({nm, ":strobe_cyc"}, 32'(strobe_cyc[i] - acc[0]), 32'(gap * i));
    end
    resp_mode = 0;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          mode;
    int          hold;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int bad;
    logic        r_we;
    logic [15:0] r_a;
    logic [31:0] r_d;
    int          r_mode;

    tbl[0] = '{1'b1, 16'h0108, 32'h0000_1234, 0, 0, 32'd0,         2};
    tbl[1] = '{1'b0, 16'h0200, 32'h0,         0, 0, 32'd12,        2};
    tbl[2] = '{1'b0, 16'h0200, 32'h0,         0, 5, 32'd12,        2};
    tbl[3] = '{1'b0, 16'h00F0, 32'h0,         1, 0, 32'hC0DE_5AAA, 1};
    tbl[4] = '{1'b1, 16'hFFFF, 32'hDEAD_BEEF, 1, 2, 32'd0,         1};
    tbl[5] = '{1'b0, 16'h0000, 32'h0,         0, 1, 32'hC0DE_5A5A, 2};

    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {rsp_rdata[15:0], addr[11:0], rsp_valid, rsp_err, busy, wen | ren},
          32'd0);
    check("reset_wdata", wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(cmd_ready), 32'd1);

    foreach (tbl[i]) begin
      resp_mode = tbl[i].mode;
      run_txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold,
              tbl[i].exp_rd, 1'b0, tbl[i].exp_lat);
    end
    resp_mode = 0;

    // Stray ack while idle must not start anything.
    bad = strobe_cnt;
    @(negedge clk); spur_ack = 1'b1;
    repeat (3) @(negedge clk);
    spur_ack = 1'b0;
    check("spur_ack", {29'd0, busy, rsp_valid, cmd_ready}, 32'b001);
    check("spur_ack_strobes", 32'(strobe_cnt - bad), 32'd0);

    b2b("b2b_1cyc", 0, 4);
    b2b("b2b_comb", 1, 3);

    // Reset while the strobe is up: strobe drops without a clock edge.
    resp_mode = 2;
    @(negedge clk);
    cmd_we = 1'b1; cmd_addr = 16'h0500; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("rst_strobe:wen", 32'(wen), 32'd1);
    rst = 1'b1; #1;
    check("rst_strobe:drop", {30'd0, wen, busy}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Reset during WAIT.
    @(negedge clk);
    cmd_we = 1'b0; cmd_addr = 16'h0200; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_wait:busy", {30'd0, busy, ren}, 32'b10);
    rst = 1'b1; #1;
    check("rst_wait:drop", {28'd0, wen, ren, busy, rsp_valid}, 32'd0);
    @(negedge clk); rst = 1'b0;
    resp_mode = 0;
    run_txn("after_rst", 1'b0, 16'h0200, 32'd0, 0, 32'd12, 1'b0, 2);

`ifdef BUSINIT_TIMEOUT_EN
    resp_mode = 2;
    run_txn("timeout", 1'b0, 16'h0300, 32'd0, 0, 32'd0, 1'b1, TO + 1);
    resp_mode = 0;
    run_txn("after_timeout", 1'b1, 16'h0108, 32'h55, 0, 32'd0, 1'b0, 2);
`else
    resp_mode = 2;
    @(negedge clk);
    cmd_we = 1'b0; cmd_addr = 16'h0300; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (!busy || rsp_valid || rsp_err) bad++;
    end
    check("no_timeout_hang", 32'(bad), 32'd0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    resp_mode = 0;
`endif

    // Random transactions against the rule-level model.
    for (int n = 0; n < 30; n++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_a    = 16'($urandom);
      r_d    = $urandom;
      r_mode = int'($urandom_range(0, 1));
      resp_mode = r_mode;
      run_txn($sformatf("rand%0d", n), r_we, r_a, r_d, int'($urandom_range(0, 3)),
              r_we ? 32'd0 : rd_fn(r_a), 1'b0, (r_mode == 1) ? 1 : 2);
    end

    check("never_both_strobes", 32'(both_hi), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
